// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester-side and FIFO-side signals of fifo_wr_arbiter
interface fifo_wr_arbiter_if #(
  parameter int NUM_IN   = 4,
  parameter int DAT_BITS = 8
);
  localparam int IDW = $clog2(NUM_IN) > 1 ? $clog2(NUM_IN) : 1;
  logic [NUM_IN-1:0]               i_val;
  logic [NUM_IN-1:0][DAT_BITS-1:0] i_dat;
  logic [NUM_IN-1:0]               i_eop;
  logic [NUM_IN-1:0]               o_rdy;
  logic                            o_val;
  logic [DAT_BITS-1:0]             o_dat;
  logic                            o_eop;
  logic [IDW-1:0]                  o_id;
  logic                            i_rdy;
  logic                            o_busy;
  logic                            o_err;
  modport slave (
    input  i_val, i_dat, i_eop, i_rdy,
    output o_rdy, o_val, o_dat, o_eop, o_id, o_busy, o_err
  );
  modport master (
    output i_val, i_dat, i_eop, i_rdy,
    input  o_rdy, o_val, o_dat, o_eop, o_id, o_busy, o_err
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-locked round-robin arbiter for a FIFO write port; FIFO_ARB_PRIO_EN gives channel 0 strict priority
module fifo_wr_arbiter #(
  parameter int NUM_IN   = 4,
  parameter int DAT_BITS = 8,
  parameter int MAX_PKT  = 256
) (
  input  logic              i_clk,
  input  logic              i_rst,
  fifo_wr_arbiter_if.slave  bus
);
  localparam int IDW = $clog2(NUM_IN) > 1 ? $clog2(NUM_IN) : 1;
  localparam int CW  = $clog2(MAX_PKT + 1);
  typedef enum logic {IDLE, LOCK} state_t;
  state_t         state, state_n;
  logic [IDW-1:0] g, g_n, lg, lg_n, pick, idx;
  logic [CW-1:0]  cnt, cnt_n;
  logic           rdy_g, acc, at_max, last;
  assign rdy_g      = state == LOCK && (!bus.o_val || bus.i_rdy);
  assign acc        = rdy_g && bus.i_val[g];
  assign at_max     = cnt == CW'(MAX_PKT - 1);
  assign last       = acc && (bus.i_eop[g] || at_max);
  assign bus.o_rdy  = rdy_g ? NUM_IN'(1) << g : '0;
  assign bus.o_busy = state == LOCK;
  // scan from farthest to nearest so the channel right after lg wins
  always_comb begin
    pick = lg;
    idx  = lg;
    for (int i = NUM_IN; i >= 1; i--) begin
      idx = IDW'((int'(lg) + i) % NUM_IN);
      if (bus.i_val[idx]) pick = idx;
    end
`ifdef FIFO_ARB_PRIO_EN
    if (bus.i_val[0]) pick = '0;
`endif
  end
  always_comb begin
    state_n = state;
    g_n     = g;
    cnt_n   = cnt;
    lg_n    = lg;
    if (state == IDLE) begin
      if (|bus.i_val) begin
        state_n = LOCK;
        g_n     = pick;
        cnt_n   = '0;
      end
    end else if (acc) begin
      cnt_n = cnt + CW'(1);
      if (last) begin
        state_n = IDLE;
        lg_n    = g;
      end
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      g         <= '0;
      lg        <= IDW'(NUM_IN - 1);
      cnt       <= '0;
      bus.o_val <= 1'b0;
      bus.o_dat <= '0;
      bus.o_eop <= 1'b0;
      bus.o_id  <= '0;
      bus.o_err <= 1'b0;
    end else begin
      state     <= state_n;
      g         <= g_n;
      lg        <= lg_n;
      cnt       <= cnt_n;
      bus.o_err <= acc && at_max && !bus.i_eop[g];
      if (acc) begin
        bus.o_val <= 1'b1;
        bus.o_dat <= bus.i_dat[g];
        bus.o_eop <= bus.i_eop[g] || at_max;
        bus.o_id  <= g;
      end else if (bus.i_rdy) begin
        bus.o_val <= 1'b0;
      end
    end
  end
endmodule
